// File: rtl/prbs_pkg.sv
// prbs_pkg: shared state encoding, run modes and PN order/length helpers for the PRBS sequencer
package prbs_pkg;
  typedef enum logic [1:0] {IDLE, SEED, RUN, DONE} state_t;
  localparam logic [1:0] MODE_CONT = 2'd0;
  localparam logic [1:0] MODE_BURST = 2'd1;
  localparam logic [1:0] MODE_SINGLE = 2'd2;
  // Entry 15 and codes 16..31 fall back to PN3
  localparam logic [4:0] PN_ORDER [16] = '{5'd3, 5'd5, 5'd7, 5'd9, 5'd11, 5'd13, 5'd15, 5'd17,
                                           5'd19, 5'd21, 5'd23, 5'd25, 5'd27, 5'd29, 5'd31, 5'd3};
  function automatic logic [4:0] pn_order(input logic [4:0] code);
    return code[4] ? 5'd3 : PN_ORDER[code[3:0]];
  endfunction
  function automatic logic [31:0] seq_len(input logic [4:0] order);
    return (32'd1 << order) - 32'd1;
  endfunction
endpackage

// File: rtl/prbs_seq_ctrl_if.sv
// prbs_seq_ctrl_if: config, run control, LFSR-core drive and status signals of the PRBS sequencer
interface prbs_seq_ctrl_if #(parameter int CNT_W = 32);
  logic [4:0] cfg_pn_select;
  logic [1:0] cfg_mode;
  logic [CNT_W-1:0] cfg_burst_len;
  logic start;
  logic stop;
  logic bit_tick_in;
  logic core_rst_n;
  logic core_clk_enable;
  logic [4:0] core_pn_select;
  logic busy;
  logic done;
  logic [CNT_W-1:0] bits_sent;
  modport master (
    output cfg_pn_select, cfg_mode, cfg_burst_len, start, stop, bit_tick_in,
    input core_rst_n, core_clk_enable, core_pn_select, busy, done, bits_sent
  );
  modport slave (
    input cfg_pn_select, cfg_mode, cfg_burst_len, start, stop, bit_tick_in,
    output core_rst_n, core_clk_enable, core_pn_select, busy, done, bits_sent
  );
endinterface

// File: rtl/prbs_seq_ctrl.sv
// prbs_seq_ctrl: sequences seed, run and completion of a PRBS LFSR core, gating its bit-rate enables
module prbs_seq_ctrl
  import prbs_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic            dac_clk,
  input  logic            reset_n,
  prbs_seq_ctrl_if.slave  bus
);
  state_t state, state_n;
  logic seed_cnt;
  logic rst_done;
  logic [4:0] pn_q;
  logic [1:0] mode_q;
  logic [CNT_W-1:0] len_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] limit;
  logic has_lim;
  logic en;
  logic last;
  assign limit = mode_q == MODE_BURST ? len_q : CNT_W'(seq_len(pn_order(pn_q)));
  assign has_lim = mode_q != MODE_CONT;
  assign en = bus.bit_tick_in && state == RUN && !bus.stop && !(has_lim && cnt_q == limit);
  assign last = has_lim && (cnt_q + CNT_W'(1)) == limit;
  always_comb begin
    state_n = state;
    case (state)
      IDLE: state_n = bus.start ? SEED : IDLE;
      SEED: state_n = !seed_cnt ? SEED : (mode_q == MODE_BURST && len_q == '0) ? DONE : RUN;
      RUN: state_n = bus.stop ? IDLE : (en && last) ? DONE : RUN;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge dac_clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      seed_cnt <= 1'b0;
      rst_done <= 1'b0;
      pn_q <= '0;
      mode_q <= '0;
      len_q <= '0;
      cnt_q <= '0;
    end else begin
      state <= state_n;
      seed_cnt <= state == SEED && !seed_cnt;
      rst_done <= 1'b1;
      if (state == IDLE && bus.start) begin
        pn_q <= bus.cfg_pn_select;
        mode_q <= bus.cfg_mode == 2'd3 ? MODE_CONT : bus.cfg_mode;
        len_q <= bus.cfg_burst_len;
        cnt_q <= '0;
      end else if (en && cnt_q != '1) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end
  assign bus.core_rst_n = rst_done && state != SEED;
  assign bus.core_clk_enable = en;
  assign bus.core_pn_select = pn_q;
  assign bus.busy = state != IDLE;
  assign bus.done = state == DONE;
  assign bus.bits_sent = cnt_q;
endmodule

// File: doc/prbs_seq_ctrl.md
PRBS_SEQ_CTRL -- requirements
Module: prbs_seq_ctrl

Interface
REQ-001 Parameter CNT_W, default 32, width of the burst length and bit counter.
REQ-002 dac_clk  in  1  single system clock; all logic on its rising edge.
REQ-003 reset_n  in  1  asynchronous active-low reset.
REQ-004 cfg_pn_select  in  5  PN order code: 0..14 = PN3,5,7,9,11,13,15,17,19,21,23,25,27,29,31; other codes = PN3.
REQ-005 cfg_mode  in  2  run mode: 0 continuous, 1 burst, 2 single sequence; 3 treated as 0.
REQ-006 cfg_burst_len  in  CNT_W  bit count for burst mode.
REQ-007 start  in  1  single-cycle pulse that begins a run.
REQ-008 stop  in  1  single-cycle pulse that aborts a run.
REQ-009 bit_tick_in  in  1  bit-rate enable pulse from the bit-rate generator; may be high on consecutive cycles.
REQ-010 core_rst_n  out  1  reseed/reset for the LFSR core.
REQ-011 core_clk_enable  out  1  gated shift enable to the LFSR core.
REQ-012 core_pn_select  out  5  latched PN code to the LFSR core.
REQ-013 busy  out  1  high in any state other than IDLE.
REQ-014 done  out  1  one-cycle pulse when a burst or sequence run completes.
REQ-015 bits_sent  out  CNT_W  number of enables issued in the current or last run.

Function
REQ-016 The FSM SHALL use states IDLE, SEED, RUN and DONE.
REQ-017 IDLE: start SHALL latch cfg_pn_select, cfg_mode and cfg_burst_len, clear bits_sent and go to SEED; stop SHALL be ignored; a same-cycle start and stop SHALL act as start.
REQ-018 SEED: core_rst_n SHALL be 0 for exactly 2 cycles, then the FSM SHALL go to RUN.
REQ-019 SEED with burst mode and latched length 0 SHALL go to DONE instead of RUN, with no enables issued.
REQ-020 core_clk_enable SHALL be combinational: bit_tick_in AND (state==RUN) AND NOT stop AND (limit not yet reached).
REQ-021 bits_sent SHALL increment on each cycle core_clk_enable is 1, and SHALL saturate at all-ones.
REQ-022 The limit SHALL be: burst mode, the latched cfg_burst_len; single-sequence mode, 2^order-1 for the latched code; continuous mode, none.
REQ-023 RUN: when an enable makes bits_sent equal the limit, the FSM SHALL go to DONE on the next edge.
REQ-024 Under REQ-023 the final bit count SHALL equal the limit exactly, even with a tick on every cycle.
REQ-025 RUN: stop SHALL go to IDLE on the next edge; that cycle's tick SHALL not be counted or passed; done SHALL not pulse.
REQ-026 A stop coinciding with the final tick SHALL win.
REQ-027 DONE SHALL last 1 cycle with done=1, then go to IDLE.
REQ-028 start outside IDLE SHALL be ignored.
REQ-029 Config inputs SHALL be ignored outside IDLE; core_pn_select SHALL change only on the latching start.
REQ-030 bits_sent SHALL hold its value after DONE or stop until the next start.
REQ-031 core_rst_n SHALL be 1 in IDLE, RUN and DONE.

Reset
REQ-032 While reset_n=0 the FSM SHALL be in IDLE, with core_rst_n=0, done=0, busy=0, bits_sent=0, core_pn_select=0 and latched config=0.
REQ-033 core_rst_n SHALL rise on the first dac_clk edge after reset_n deasserts.
REQ-034 Reset mid-run SHALL abort immediately with no done pulse.

Structure
REQ-035 A shared package prbs_pkg SHALL hold the state encoding, the mode constants, the PN code-to-order table and a sequence-length function (2^order-1, CNT_W wide, order 31 fits in 32 bits).
REQ-036 The block SHALL contain no sub-module.
REQ-037 The LFSR core and the bit-rate generator SHALL be instantiated by the parent, not by this block.

Verification
REQ-038 Burst: mode=1, len=5, tick every cycle, start -> exactly 5 enables, bits_sent=5, a single done pulse, busy falls the cycle after done.
REQ-039 Single sequence: mode=2, pn=0, tick every 3rd cycle -> exactly 7 enables, then done.
REQ-040 Single sequence: mode=2, pn=2 -> exactly 127 enables.
REQ-041 Stop: continuous mode, stop with tick on enable 10 -> core_clk_enable=0 that cycle, bits_sent=9, IDLE next cycle, no done.
REQ-042 Zero length: mode=1, len=0 -> core_rst_n low 2 cycles, done pulse, bits_sent=0, no enables.
REQ-043 Config isolation: cfg_pn_select changed and start re-pulsed during RUN -> core_pn_select unchanged, run unaffected.
REQ-044 Reset: reset_n asserted mid-RUN -> all outputs at reset values asynchronously; core_rst_n=1 on the first edge after release.
